// File: rtl/ar_envelope.sv
// Attack/release envelope generator with VCA output stage, clocked at the sample rate.
// Build option: define AR_EXP_RELEASE_EN for a quasi-exponential release tail.
module ar_envelope #(
  parameter int BITDEPTH  = 14,
  parameter int ACC_WIDTH = 16
) (
  input  logic                sample_clock,
  input  logic                rst_n,
  input  logic [BITDEPTH-1:0] in,
  input  logic [7:0]          envelope_attack,
  input  logic [7:0]          envelope_decay,
  input  logic                gate,
  output logic [BITDEPTH-1:0] out
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};

  state_t                 state_r;
  logic [ACC_WIDTH-1:0]   acc_r;
  logic [ACC_WIDTH:0]     acc_up_s;
  logic [ACC_WIDTH:0]     dec_s;
  logic [ACC_WIDTH:0]     acc_dn_s;
  logic [ACC_WIDTH-1:0]   acc_up_sat_s;
  logic [ACC_WIDTH-1:0]   acc_dn_sat_s;
  logic [8:0]             level9_s;

  // Saturating ramp arithmetic and gain derived from the current (pre-update) level
  always_comb begin
    acc_up_s     = {1'b0, acc_r} + {9'd0, envelope_attack};
`ifdef AR_EXP_RELEASE_EN
    dec_s        = {7'd0, acc_r[ACC_WIDTH-1:6]} + {9'd0, envelope_decay};
`else
    dec_s        = {9'd0, envelope_decay};
`endif
    acc_dn_s     = {1'b0, acc_r} - dec_s;
    acc_up_sat_s = ACC_MAX;
    acc_dn_sat_s = '0;
    level9_s     = 9'd0;
    if (acc_up_s[ACC_WIDTH]) begin
      acc_up_sat_s = ACC_MAX;
    end else begin
      acc_up_sat_s = acc_up_s[ACC_WIDTH-1:0];
    end
    // A set top bit means the subtraction borrowed, i.e. the result went below zero.
    if (acc_dn_s[ACC_WIDTH]) begin
      acc_dn_sat_s = '0;
    end else begin
      acc_dn_sat_s = acc_dn_s[ACC_WIDTH-1:0];
    end
    // Full scale maps to unity gain so a sustained note passes through untouched.
    if (acc_r == ACC_MAX) begin
      level9_s = 9'd256;
    end else begin
      level9_s = {1'b0, acc_r[ACC_WIDTH-1:ACC_WIDTH-8]};
    end
  end

  // Envelope state machine, level accumulator and registered VCA output
  always_ff @(posedge sample_clock) begin
    if (!rst_n) begin
      state_r <= IDLE;
      acc_r   <= '0;
      out     <= '0;
    end else begin
      out <= BITDEPTH'(({9'd0, in} * {{BITDEPTH{1'b0}}, level9_s}) >> 8);
      case (state_r)
        IDLE: begin
          acc_r <= '0;
          if (gate) begin
            state_r <= ATTACK;
          end
        end
        ATTACK: begin
          if (!gate) begin
            state_r <= RELEASE;
          end else begin
            acc_r <= acc_up_sat_s;
            if (acc_up_sat_s == ACC_MAX) begin
              state_r <= SUSTAIN;
            end
          end
        end
        SUSTAIN: begin
          acc_r <= ACC_MAX;
          if (!gate) begin
            state_r <= RELEASE;
          end
        end
        RELEASE: begin
          // Re-pressing the gate resumes the attack from the current level.
          if (gate) begin
            state_r <= ATTACK;
          end else begin
            acc_r <= acc_dn_sat_s;
            if (acc_dn_sat_s == '0) begin
              state_r <= IDLE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          acc_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ar_envelope.sv
// Self-checking bench for ar_envelope: a cycle model pushes expected outputs to a scoreboard.
module tb_ar_envelope;
  localparam int BD = 14;

  logic          sample_clock = 1'b0;
  logic          rst_n;
  logic [BD-1:0] in_s;
  logic [7:0]    attack_s;
  logic [7:0]    decay_s;
  logic          gate_s;
  logic [BD-1:0] out_s;

  int checks = 0;
  int errors = 0;
  logic [BD-1:0] sb[$];
  logic [BD-1:0] exp_v;

  // model state: 0 idle, 1 attack, 2 sustain, 3 release
  int m_acc   = 0;
  int m_state = 0;

  ar_envelope #(.BITDEPTH(BD), .ACC_WIDTH(16)) dut (
    .sample_clock   (sample_clock),
    .rst_n          (rst_n),
    .in             (in_s),
    .envelope_attack(attack_s),
    .envelope_decay (decay_s),
    .gate           (gate_s),
    .out            (out_s)
  );

  always #5 sample_clock = ~sample_clock;

  // push the expected output for the coming edge, advance the model, then advance one clock
  task automatic tick();
    int lvl;
    int n;
    int d;
    logic [BD-1:0] e;
    if (!rst_n) begin
      e = '0;
      m_acc = 0;
      m_state = 0;
    end else begin
      lvl = (m_acc == 65535) ? 256 : (m_acc / 256);
      e = BD'((int'(in_s) * lvl) / 256);
      case (m_state)
        0: begin m_acc = 0; if (gate_s) m_state = 1; end
        1: begin
          if (!gate_s) m_state = 3;
          else begin
            n = m_acc + int'(attack_s);
            if (n >= 65535) n = 65535;
            m_acc = n;
            if (n == 65535) m_state = 2;
          end
        end
        2: begin if (!gate_s) m_state = 3; end
        default: begin
          if (gate_s) m_state = 1;
          else begin
            d = int'(decay_s);
`ifdef AR_EXP_RELEASE_EN
            d = d + m_acc / 64;
`endif
            n = m_acc - d;
            if (n <= 0) n = 0;
            m_acc = n;
            if (n == 0) m_state = 0;
          end
        end
      endcase
    end
    sb.push_back(e);
    @(posedge sample_clock);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; gate_s = 1'b1; in_s = 14'h2000; attack_s = 8'hF0; decay_s = 8'h30;
    repeat (2) begin
      tick(); exp_v = sb.pop_front(); checks++;
      if (out_s !== exp_v) begin errors++; $display("FAIL reset_hold: out=%0d expected %0d", out_s, exp_v); end
    end
    checks++;
    if (out_s !== 14'd0) begin errors++; $display("FAIL reset_out_zero: out=%0d expected 0", out_s); end
    rst_n = 1'b1;
    repeat (3) begin
      tick(); exp_v = sb.pop_front(); checks++;
      if (out_s !== exp_v) begin errors++; $display("FAIL reset_release: out=%0d expected %0d", out_s, exp_v); end
    end
  endtask

  task automatic test_attack();
    rst_n = 1'b0; gate_s = 1'b1; in_s = 14'd8192; attack_s = 8'hF0;
    tick(); exp_v = sb.pop_front(); checks++;
    if (out_s !== exp_v) begin errors++; $display("FAIL attack_reset: out=%0d expected %0d", out_s, exp_v); end
    rst_n = 1'b1;
    tick(); exp_v = sb.pop_front(); checks++;
    if (out_s !== exp_v) begin errors++; $display("FAIL attack_start: out=%0d expected %0d", out_s, exp_v); end
    for (int k = 1; k <= 275; k++) begin
      tick(); exp_v = sb.pop_front(); checks++;
      if (out_s !== exp_v) begin errors++; $display("FAIL attack_ramp k=%0d: out=%0d expected %0d", k, out_s, exp_v); end
      if (k == 274) begin
        checks++;
        if (out_s !== 14'd8160) begin errors++; $display("FAIL attack_pre_sat: out=%0d expected 8160", out_s); end
      end
      if (k == 275) begin
        checks++;
        if (out_s !== 14'd8192) begin errors++; $display("FAIL attack_unity: out=%0d expected 8192", out_s); end
      end
    end
  endtask

  task automatic test_release();
    in_s = 14'd16383; decay_s = 8'h30; gate_s = 1'b0;
    for (int j = 0; j <= 1369; j++) begin
      tick(); exp_v = sb.pop_front(); checks++;
      if (out_s !== exp_v) begin errors++; $display("FAIL release j=%0d: out=%0d expected %0d", j, out_s, exp_v); end
`ifndef AR_EXP_RELEASE_EN
      if (j == 2) begin
        checks++;
        if (out_s !== 14'd16319) begin errors++; $display("FAIL release_first_dec: out=%0d expected 16319", out_s); end
      end
`endif
    end
    checks++;
    if (out_s !== 14'd0) begin errors++; $display("FAIL release_settled: out=%0d expected 0", out_s); end
  endtask

  task automatic test_mid_gain();
    rst_n = 1'b0; gate_s = 1'b1; in_s = 14'd8192; attack_s = 8'h80;
    tick(); exp_v = sb.pop_front(); checks++;
    if (out_s !== exp_v) begin errors++; $display("FAIL mid_reset: out=%0d expected %0d", out_s, exp_v); end
    rst_n = 1'b1;
    repeat (258) begin
      tick(); exp_v = sb.pop_front(); checks++;
      if (out_s !== exp_v) begin errors++; $display("FAIL mid_ramp: out=%0d expected %0d", out_s, exp_v); end
    end
    checks++;
    if (out_s !== 14'd4096) begin errors++; $display("FAIL mid_half_gain: out=%0d expected 4096", out_s); end
    rst_n = 1'b0; attack_s = 8'hFF;
    tick(); exp_v = sb.pop_front(); checks++;
    if (out_s !== exp_v) begin errors++; $display("FAIL mid_reset2: out=%0d expected %0d", out_s, exp_v); end
    rst_n = 1'b1;
    repeat (2) begin
      tick(); exp_v = sb.pop_front(); checks++;
      if (out_s !== exp_v) begin errors++; $display("FAIL mid_ff_ramp: out=%0d expected %0d", out_s, exp_v); end
    end
    in_s = 14'd16383;
    tick(); exp_v = sb.pop_front(); checks++;
    if (out_s !== exp_v) begin errors++; $display("FAIL mid_ff: out=%0d expected %0d", out_s, exp_v); end
    checks++;
    if (out_s !== 14'd0) begin errors++; $display("FAIL mid_below_256: out=%0d expected 0", out_s); end
  endtask

  task automatic test_retrigger();
    int guard;
    rst_n = 1'b0; gate_s = 1'b1; in_s = 14'd8192; attack_s = 8'hF0; decay_s = 8'h30;
    tick(); exp_v = sb.pop_front();
    rst_n = 1'b1;
    guard = 0;
    while (m_state != 2 && guard < 400) begin
      tick(); exp_v = sb.pop_front(); checks++; guard++;
      if (out_s !== exp_v) begin errors++; $display("FAIL retrig_attack: out=%0d expected %0d", out_s, exp_v); end
    end
    gate_s = 1'b0;
    guard = 0;
    while (m_acc > 16384 && guard < 2000) begin
      tick(); exp_v = sb.pop_front(); checks++; guard++;
      if (out_s !== exp_v) begin errors++; $display("FAIL retrig_release: out=%0d expected %0d", out_s, exp_v); end
    end
    gate_s = 1'b1;
    repeat (6) begin
      tick(); exp_v = sb.pop_front(); checks++;
      if (out_s !== exp_v) begin errors++; $display("FAIL retrig_resume: out=%0d expected %0d", out_s, exp_v); end
    end
    checks++;
    if (out_s < 14'd1900) begin errors++; $display("FAIL retrig_no_restart: out=%0d expected at least 1900", out_s); end
    rst_n = 1'b0;
    tick(); exp_v = sb.pop_front(); checks++;
    if (out_s !== 14'd0 || out_s !== exp_v) begin errors++; $display("FAIL retrig_mid_reset: out=%0d expected 0", out_s); end
    rst_n = 1'b1;
  endtask

  task automatic test_zero_rates();
    rst_n = 1'b0; gate_s = 1'b1; in_s = 14'd16383; attack_s = 8'h00; decay_s = 8'h00;
    tick(); exp_v = sb.pop_front();
    rst_n = 1'b1;
    repeat (20) begin
      tick(); exp_v = sb.pop_front(); checks++;
      if (out_s !== exp_v) begin errors++; $display("FAIL zero_attack: out=%0d expected %0d", out_s, exp_v); end
    end
    checks++;
    if (out_s !== 14'd0) begin errors++; $display("FAIL zero_attack_out: out=%0d expected 0", out_s); end
    attack_s = 8'h80;
    repeat (100) begin
      tick(); exp_v = sb.pop_front(); checks++;
      if (out_s !== exp_v) begin errors++; $display("FAIL zero_prep: out=%0d expected %0d", out_s, exp_v); end
    end
    gate_s = 1'b0;
    repeat (30) begin
      tick(); exp_v = sb.pop_front(); checks++;
      if (out_s !== exp_v) begin errors++; $display("FAIL zero_decay: out=%0d expected %0d", out_s, exp_v); end
    end
`ifndef AR_EXP_RELEASE_EN
    checks++;
    if (out_s !== 14'd3199) begin errors++; $display("FAIL zero_decay_frozen: out=%0d expected 3199", out_s); end
`endif
  endtask

  initial begin
    rst_n = 1'b0; gate_s = 1'b0; in_s = '0; attack_s = '0; decay_s = '0;
    test_reset();
    test_attack();
    test_release();
    test_mid_gain();
    test_retrigger();
    test_zero_rates();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
